// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the pong datapath: it decides when the animation runs
// or is frozen, counts the balls left and a 2-digit BCD score, and times the pause
// after each miss and at game over.
module pong_game_ctrl #(
  parameter int unsigned BALLS        = 3,
  parameter int unsigned DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [1:0] ball_left,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       timer_up
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ball_left_q, ball_left_d;
  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig0_q, dig0_d;
  logic [6:0] timer_q, timer_d;
  logic       btn_any;
  logic       timer_zero;

  assign btn_any    = (btn != '0);
  assign timer_zero = (timer_q == '0);

  // State and counter registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NEWGAME;
      ball_left_q <= 2'(BALLS);
      dig1_q      <= '0;
      dig0_q      <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      ball_left_q <= ball_left_d;
      dig1_q      <= dig1_d;
      dig0_q      <= dig0_d;
      timer_q     <= timer_d;
    end
  end

  // Next-state, ball/score counting and pause timer; a timer load beats frame_tick.
  always_comb begin
    state_d     = state_q;
    ball_left_d = ball_left_q;
    dig1_d      = dig1_q;
    dig0_d      = dig0_q;
    timer_d     = timer_q;

    if (frame_tick && !timer_zero) begin
      timer_d = timer_q - 7'd1;
    end

    unique case (state_q)
      NEWGAME: begin
        if (btn_any) begin
          state_d     = PLAY;
          ball_left_d = 2'(BALLS - 1);
          dig1_d      = '0;
          dig0_d      = '0;
        end
      end
      PLAY: begin
        if (miss) begin
          timer_d = 7'(DELAY_FRAMES);
          if (ball_left_q == '0) begin
            state_d = OVER;
          end else begin
            state_d     = NEWBALL;
            ball_left_d = ball_left_q - 2'd1;
          end
        end else if (hit) begin
          if (dig0_q == 4'd9) begin
            dig0_d = '0;
            dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
          end else begin
            dig0_d = dig0_q + 4'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_zero && btn_any) begin
          state_d = PLAY;
        end
      end
      OVER: begin
        if (timer_zero) begin
          state_d     = NEWGAME;
          ball_left_d = 2'(BALLS);
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Outputs are decoded from registers only.
  always_comb begin
    gra_still  = (state_q != PLAY);
    game_state = state_q;
    ball_left  = ball_left_q;
    dig1       = dig1_q;
    dig0       = dig0_q;
    timer_up   = timer_zero;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: a directed vector table, hand-written pause/game-over
// sequences, then random stimulus, all checked against an integer game model.
module tb_pong_game_ctrl;

  localparam int BALLS = 3;
  localparam int DELAY = 120;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic       frame_tick, hit, miss;
  logic       gra_still, timer_up;
  logic [1:0] game_state, ball_left;
  logic [3:0] dig1, dig0;

  int checks = 0;
  int errors = 0;

  // Game model: state 0..3, balls remaining, score as an integer 0..99, frames left.
  int m_st, m_bl, m_score, m_tm;
  bit m_just_reset;

  pong_game_ctrl #(.BALLS(BALLS), .DELAY_FRAMES(DELAY)) dut (
    .clk(clk), .reset(reset), .btn(btn), .frame_tick(frame_tick),
    .hit(hit), .miss(miss), .gra_still(gra_still), .game_state(game_state),
    .ball_left(ball_left), .dig1(dig1), .dig0(dig0), .timer_up(timer_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input int b, input bit f, input bit h, input bit m);
    bit expired;
    int nt;
    m_just_reset = r;
    if (r) begin
      m_st = 0; m_bl = BALLS; m_score = 0; m_tm = 0;
      return;
    end
    expired = (m_tm == 0);
    nt = (f && m_tm > 0) ? m_tm - 1 : m_tm;
    case (m_st)
      0: if (b != 0) begin m_st = 1; m_bl = BALLS - 1; m_score = 0; end
      1: begin
        if (m) begin
          nt = DELAY;
          if (m_bl == 0) m_st = 3;
          else begin m_st = 2; m_bl = m_bl - 1; end
        end else if (h) m_score = (m_score + 1) % 100;
      end
      2: if (expired && b != 0) m_st = 1;
      default: if (expired) begin m_st = 0; m_bl = BALLS; end
    endcase
    m_tm = nt;
  endtask

  task automatic step(input bit r, input int b, input bit f, input bit h, input bit m);
    reset = r; btn = 2'(b); frame_tick = f; hit = h; miss = m;
    @(posedge clk);
    model_edge(r, b, f, h, m);
    #1;
    chk("model_state", int'(game_state), m_st);
    chk("model_still", int'(gra_still), (m_st != 1) ? 1 : 0);
    chk("model_balls", int'(ball_left), m_bl);
    chk("model_dig1", int'(dig1), m_score / 10);
    chk("model_dig0", int'(dig0), m_score % 10);
    if (m_st >= 2 || m_just_reset)
      chk("model_timer_up", int'(timer_up), (m_tm == 0) ? 1 : 0);
  endtask

  typedef struct {
    bit r; int b; bit f; bit h; bit m;
    int e_st; int e_bl; int e_d1; int e_d0; int e_still;
  } vec_t;

  vec_t vt[9];

  initial begin
    reset = 1'b1; btn = '0; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0;
    m_st = 0; m_bl = BALLS; m_score = 0; m_tm = 0; m_just_reset = 1'b0;

    //          r  btn ft hit miss  st bl d1 d0 still
    vt[0] = '{1, 0, 0, 0, 0,   0, 3, 0, 0, 1};
    vt[1] = '{0, 0, 0, 0, 0,   0, 3, 0, 0, 1};
    vt[2] = '{0, 1, 0, 0, 0,   1, 2, 0, 0, 0};
    vt[3] = '{0, 0, 0, 1, 0,   1, 2, 0, 1, 0};
    vt[4] = '{0, 0, 1, 1, 0,   1, 2, 0, 2, 0};
    vt[5] = '{0, 0, 0, 1, 1,   2, 1, 0, 2, 1};
    vt[6] = '{0, 0, 1, 1, 0,   2, 1, 0, 2, 1};
    vt[7] = '{0, 3, 0, 0, 0,   2, 1, 0, 2, 1};
    vt[8] = '{1, 3, 1, 1, 1,   0, 3, 0, 0, 1};

    for (int unsigned i = 0; i < 9; i++) begin
      step(vt[i].r, vt[i].b, vt[i].f, vt[i].h, vt[i].m);
      chk("vec_state", int'(game_state), vt[i].e_st);
      chk("vec_balls", int'(ball_left), vt[i].e_bl);
      chk("vec_dig1", int'(dig1), vt[i].e_d1);
      chk("vec_dig0", int'(dig0), vt[i].e_d0);
      chk("vec_still", int'(gra_still), vt[i].e_still);
    end
    chk("reset_timer_up", int'(timer_up), 1);

    // Score counting and wrap at 99.
    step(0, 1, 0, 0, 0);
    repeat (12) step(0, 0, 0, 1, 0);
    chk("score12_d1", int'(dig1), 1);
    chk("score12_d0", int'(dig0), 2);
    repeat (87) step(0, 0, 0, 1, 0);
    chk("score99_d1", int'(dig1), 9);
    chk("score99_d0", int'(dig0), 9);
    step(0, 0, 0, 1, 0);
    chk("wrap_d1", int'(dig1), 0);
    chk("wrap_d0", int'(dig0), 0);
    repeat (5) step(0, 0, 0, 1, 0);

    // Miss with a coincident frame_tick: the load wins, so the pause is a full 120 ticks.
    step(0, 0, 1, 0, 1);
    chk("miss1_state", int'(game_state), 2);
    chk("miss1_balls", int'(ball_left), 1);
    repeat (119) step(0, 3, 1, 0, 0);
    chk("pause119_state", int'(game_state), 2);
    chk("pause119_timer_up", int'(timer_up), 0);
    step(0, 3, 1, 0, 0);
    chk("pause120_timer_up", int'(timer_up), 1);
    chk("pause120_state", int'(game_state), 2);
    step(0, 3, 0, 0, 0);
    chk("resume_state", int'(game_state), 1);

    // Last ball, game over, score retained into NEWGAME.
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("miss2_balls", int'(ball_left), 0);
    repeat (DELAY) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("over_state", int'(game_state), 3);
    repeat (DELAY) step(0, 0, 1, 0, 0);
    chk("over_wait_state", int'(game_state), 3);
    step(0, 0, 0, 0, 0);
    chk("newgame_state", int'(game_state), 0);
    chk("newgame_balls", int'(ball_left), 3);
    chk("kept_d0", int'(dig0), 8);
    step(0, 2, 0, 0, 0);
    chk("restart_state", int'(game_state), 1);
    chk("restart_d0", int'(dig0), 0);

    // Reset in the middle of a pause (timer at 50).
    repeat (2) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    repeat (DELAY - 50) step(0, 0, 1, 0, 0);
    step(1, 3, 1, 1, 1);
    chk("midreset_state", int'(game_state), 0);
    chk("midreset_balls", int'(ball_left), 3);
    chk("midreset_d0", int'(dig0), 0);

    // Random play against the model.
    for (int unsigned n = 0; n < 3000; n++) begin
      step(($urandom_range(199) == 0),
           ($urandom_range(2) == 0) ? int'($urandom_range(3)) : 0,
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
